// File: rtl/tone_step_sequencer.sv
// tone_step_sequencer
//   Programmable step sequencer that feeds the clock divider stage. A table of
//   STEPS 12-bit entries (bit 11 = rest, bits 10:0 = divider scale factor) is
//   played one entry per step. Each step lasts dur_ticks+1 ticks. After step
//   seq_last the sequence wraps to step 0 (loop=1) or stops and pulses done.
//
//   Optional feature macro: TONE_SEQ_GAP_EN
//     Inserts a one-tick silent GAP between consecutive steps.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   wr_en/addr/data     table write port, accepted in every state
//   seq_last, loop      last played index, wrap enable (sampled at step end)
//   dur_ticks, tick     step length minus one, duration time-base strobe
//   start, stop         begin sequence (IDLE only), abort (any state, wins)
//   scale_factor        divider scale factor
//   scale_en            divider enable (0 in IDLE, during rests and GAP)
//   scale_rst           divider reset, one-cycle pulse per step load
//   step_idx            current step
//   busy                high outside IDLE
//   done                one-cycle pulse at non-loop sequence end
module tone_step_sequencer #(
    parameter int unsigned STEPS = 8,
    parameter int unsigned IDX_W = 3,
    parameter int unsigned DUR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [11:0]      wr_data,
    input  logic [IDX_W-1:0] seq_last,
    input  logic             loop,
    input  logic [DUR_W-1:0] dur_ticks,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    output logic [10:0]      scale_factor,
    output logic             scale_en,
    output logic             scale_rst,
    output logic [IDX_W-1:0] step_idx,
    output logic             busy,
    output logic             done
);

`ifdef TONE_SEQ_GAP_EN
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif

    state_t           state, state_d;
    logic [DUR_W-1:0] cnt, cnt_d;
    logic [11:0]      tbl [STEPS];

    logic [10:0]      sf_d;
    logic             en_d;
    logic             srst_d;
    logic [IDX_W-1:0] idx_d;
    logic             done_d;

    logic             load;
    logic [IDX_W-1:0] load_idx;
    logic [IDX_W-1:0] nxt_idx;
    logic             last_step;
    logic [11:0]      entry;

`ifdef TONE_SEQ_GAP_EN
    // Step to load when the GAP ends; captured at the step end so seq_last
    // and loop are sampled at the same point as in the gap-less build.
    logic [IDX_W-1:0] pend_idx, pend_d;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        sf_d      = scale_factor;
        en_d      = scale_en;
        srst_d    = 1'b0;
        idx_d     = step_idx;
        done_d    = 1'b0;
        load      = 1'b0;
        load_idx  = '0;
`ifdef TONE_SEQ_GAP_EN
        pend_d    = pend_idx;
`endif
        // ">=" so an index already beyond seq_last also ends the sequence.
        last_step = (step_idx >= seq_last);
        nxt_idx   = last_step ? '0 : step_idx + IDX_W'(1);

        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (cnt != dur_ticks) begin
                        cnt_d = cnt + DUR_W'(1);
                    end else if (last_step && !loop) begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
`ifdef TONE_SEQ_GAP_EN
                        state_d = GAP;
                        en_d    = 1'b0;
                        pend_d  = nxt_idx;
`else
                        load     = 1'b1;
                        load_idx = nxt_idx;
`endif
                    end
                end
            end
`ifdef TONE_SEQ_GAP_EN
            GAP: begin
                if (tick) begin
                    load     = 1'b1;
                    load_idx = pend_idx;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Table is read before this edge's write lands, so a write to the
        // step being loaded only shows at that step's next load.
        entry = tbl[load_idx];
        if (load) begin
            state_d = PLAY;
            sf_d    = entry[10:0];
            en_d    = ~entry[11];
            srst_d  = 1'b1;
            cnt_d   = '0;
            idx_d   = load_idx;
        end

        // Abort overrides everything, including a same-cycle start.
        if (stop) begin
            state_d = IDLE;
            en_d    = 1'b0;
            srst_d  = 1'b0;
            done_d  = 1'b0;
            sf_d    = scale_factor;
            idx_d   = step_idx;
            cnt_d   = cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            scale_factor <= '0;
            scale_en     <= 1'b0;
            scale_rst    <= 1'b0;
            step_idx     <= '0;
            done         <= 1'b0;
            tbl          <= '{default: '0};
`ifdef TONE_SEQ_GAP_EN
            pend_idx     <= '0;
`endif
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            scale_factor <= sf_d;
            scale_en     <= en_d;
            scale_rst    <= srst_d;
            step_idx     <= idx_d;
            done         <= done_d;
`ifdef TONE_SEQ_GAP_EN
            pend_idx     <= pend_d;
`endif
            if (wr_en) begin
                tbl[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_tone_step_sequencer.sv
// Testbench for tone_step_sequencer: directed scenarios plus randomized
// stimulus, every cycle compared against a step-level reference model.
module tb_tone_step_sequencer;
    localparam int unsigned STEPS = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned DUR_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [IDX_W-1:0] wr_addr = '0;
    logic [11:0]      wr_data = '0;
    logic [IDX_W-1:0] seq_last = '0;
    logic             loop = 1'b0;
    logic [DUR_W-1:0] dur_ticks = '0;
    logic             tick = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [10:0]      scale_factor;
    logic             scale_en;
    logic             scale_rst;
    logic [IDX_W-1:0] step_idx;
    logic             busy;
    logic             done;

    tone_step_sequencer #(.STEPS(STEPS), .IDX_W(IDX_W), .DUR_W(DUR_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .seq_last(seq_last), .loop(loop),
        .dur_ticks(dur_ticks), .tick(tick), .start(start), .stop(stop),
        .scale_factor(scale_factor), .scale_en(scale_en),
        .scale_rst(scale_rst), .step_idx(step_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a sequence is a list of steps, each with a number of
    // ticks remaining; the table is a plain array.
    logic [11:0] m_tbl [STEPS];
    bit          m_busy, m_en, m_rst, m_done, m_gap;
    int unsigned m_idx, m_next;
    logic [10:0] m_sf;
    int          m_left;

    int          n_rst, n_done;
    logic [10:0] sf_q[$];
    bit          en_q[$];

    task automatic model_reset();
        for (int i = 0; i < STEPS; i++) m_tbl[i] = '0;
        m_busy = 0; m_en = 0; m_rst = 0; m_done = 0; m_gap = 0;
        m_idx = 0; m_next = 0; m_sf = '0; m_left = 0;
    endtask

    task automatic begin_step(input int unsigned i);
        m_idx  = i;
        m_sf   = m_tbl[i][10:0];
        m_en   = !m_tbl[i][11];
        m_rst  = 1;
        m_left = int'(dur_ticks) + 1;
        m_busy = 1;
        m_gap  = 0;
    endtask

    task automatic model_edge();
        int unsigned n;
        bit          last;
        m_rst  = 0;
        m_done = 0;
        last   = (m_idx >= int'(seq_last));
        if (stop) begin
            m_busy = 0; m_en = 0; m_gap = 0;
        end else if (!m_busy) begin
            if (start) begin_step(0);
        end else if (tick) begin
            if (m_gap) begin
                begin_step(m_next);
            end else if (m_left > 1) begin
                m_left--;
            end else if (last && !loop) begin
                m_busy = 0; m_en = 0; m_done = 1;
            end else begin
                n = last ? 0 : (m_idx + 1) % STEPS;
                m_next = n;
`ifdef TONE_SEQ_GAP_EN
                m_gap = 1;
                m_en  = 0;
`else
                begin_step(n);
`endif
            end
        end
        if (wr_en) m_tbl[wr_addr] = wr_data;
    endtask

    task automatic compare_all();
        check_val("scale_factor", scale_factor, m_sf);
        check_val("scale_en", scale_en, m_en);
        check_val("scale_rst", scale_rst, m_rst);
        check_val("step_idx", step_idx, m_idx);
        check_val("busy", busy, m_busy);
        check_val("done", done, m_done);
    endtask

    // Called at a falling edge: apply tick, run one clock, check outputs.
    task automatic cycle(input bit t);
        tick = t;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        if (scale_rst === 1'b1) begin
            n_rst++;
            sf_q.push_back(scale_factor);
            en_q.push_back(scale_en);
        end
        if (done === 1'b1) n_done++;
        wr_en = 0; start = 0; stop = 0;
    endtask

    task automatic write_entry(input int unsigned a, input logic [11:0] d);
        wr_en = 1; wr_addr = IDX_W'(a); wr_data = d;
        cycle(0);
    endtask

    task automatic clear_counts();
        n_rst = 0; n_done = 0;
        sf_q.delete(); en_q.delete();
    endtask

    initial begin
        model_reset();
        clear_counts();
        @(negedge clk);
        check_val("rst_sf", scale_factor, 0);
        check_val("rst_en", scale_en, 0);
        check_val("rst_srst", scale_rst, 0);
        check_val("rst_idx", step_idx, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        rst_n = 1;

        // Three-step non-looping melody, step 2 a rest.
        write_entry(0, 12'h010);
        write_entry(1, 12'h020);
        write_entry(2, 12'h830);
        seq_last = 2; loop = 0; dur_ticks = 1;
        clear_counts();
        start = 1; cycle(0);
        for (int k = 0; k < 40 && busy; k++) cycle(k % 2 == 0);
        check_val("p1_end", busy, 0);
        check_val("p1_nrst", n_rst, 3);
        check_val("p1_ndone", n_done, 1);
        if (sf_q.size() == 3) begin
            check_val("p1_sf0", sf_q[0], 11'h010);
            check_val("p1_sf1", sf_q[1], 11'h020);
            check_val("p1_sf2", sf_q[2], 11'h030);
            check_val("p1_en0", en_q[0], 1);
            check_val("p1_en1", en_q[1], 1);
            check_val("p1_en2", en_q[2], 0);
        end

        // Looping: three full loops plus the reload of step 0, no done.
        loop = 1;
        clear_counts();
        start = 1; cycle(0);
        for (int k = 0; k < 200 && n_rst < 10; k++) cycle(k % 2 == 0);
        check_val("p2_nrst", n_rst, 10);
        check_val("p2_ndone", n_done, 0);
        if (sf_q.size() >= 4) check_val("p2_reload", sf_q[3], 11'h010);

        // Abort in step 1, stop wins over start in IDLE.
        stop = 1; cycle(0);
        clear_counts();
        start = 1; cycle(0);
        for (int k = 0; k < 20 && step_idx != 1; k++) cycle(1);
        check_val("p3_reach", step_idx, 1);
        stop = 1; cycle(0);
        check_val("p3_busy", busy, 0);
        check_val("p3_en", scale_en, 0);
        check_val("p3_done", n_done, 0);
        stop = 1; start = 1; cycle(0);
        check_val("p3_stay", busy, 0);

        // Rewrite the step currently playing.
        dur_ticks = 3;
        start = 1; cycle(0);
        for (int k = 0; k < 40 && !(step_idx == 1 && scale_rst); k++) cycle(1);
        check_val("p4_reach", step_idx, 1);
        write_entry(1, 12'h055);
        check_val("p4_old", scale_factor, 11'h020);
        cycle(1);
        for (int k = 0; k < 60 && !(step_idx == 1 && scale_rst); k++) cycle(1);
        check_val("p4_new", scale_factor, 11'h055);
        stop = 1; cycle(0);

        // One-tick single-step sequence, start while busy ignored.
        dur_ticks = 0; seq_last = 0; loop = 0;
        clear_counts();
        start = 1; cycle(1);
        cycle(1);
        check_val("p5_done", done, 1);
        dur_ticks = 3;
        start = 1; cycle(0);
        start = 1; cycle(0);
        check_val("p5_ignore", n_rst, 2);
        stop = 1; cycle(0);

`ifdef TONE_SEQ_GAP_EN
        // Gap between steps: enable pattern 1,0,1,0 over consecutive ticks.
        write_entry(1, 12'h020);
        dur_ticks = 0; seq_last = 1; loop = 1;
        start = 1; cycle(1);
        check_val("g_en0", scale_en, 1);
        cycle(1);
        check_val("g_en1", scale_en, 0);
        check_val("g_idx", step_idx, 0);
        cycle(1);
        check_val("g_en2", scale_en, 1);
        cycle(1);
        check_val("g_en3", scale_en, 0);
        stop = 1; cycle(0);
`endif

        // Randomized traffic; dur_ticks only changes while idle.
        for (int k = 0; k < 3000; k++) begin
            if (!m_busy && $urandom_range(0, 9) == 0) dur_ticks = DUR_W'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) seq_last = IDX_W'($urandom_range(0, STEPS - 1));
            if ($urandom_range(0, 19) == 0) loop = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                wr_en = 1;
                wr_addr = IDX_W'($urandom_range(0, STEPS - 1));
                wr_data = 12'($urandom);
            end
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            cycle(1'($urandom_range(0, 1)));

            // Asynchronous reset in the middle of a sequence, once.
            if (k == 1500) begin
                seq_last = 3'd7; loop = 1; stop = 0;
                start = 1; cycle(1);
                cycle(0);
                #2 rst_n = 0;
                #1;
                check_val("ar_sf", scale_factor, 0);
                check_val("ar_en", scale_en, 0);
                check_val("ar_idx", step_idx, 0);
                check_val("ar_busy", busy, 0);
                check_val("ar_srst", scale_rst, 0);
                model_reset();
                @(negedge clk);
                rst_n = 1;
                start = 1; cycle(0);
                check_val("ar_tbl", scale_factor, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
